// File: rtl/router_nch.sv
// Packet router. A single byte stream of length-prefixed, parity-terminated packets is
// steered into NUM_CH tagged FIFOs. Bad addresses are dropped; channels left unread too long are flushed.
module router_nch #(
    parameter int DATA_W  = 8,
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 2,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pkt_valid,
    input  logic [DATA_W-1:0]        din,
    input  logic [NUM_CH-1:0]        rd_en,
    output logic [NUM_CH*DATA_W-1:0] dout,
    output logic [NUM_CH-1:0]        sop,
    output logic [NUM_CH-1:0]        vld_out,
    output logic                     busy,
    output logic                     err,
    output logic                     drop,
    output logic [NUM_CH-1:0]        sft_rst
);

    localparam int LEN_W = DATA_W - ADDR_W;
    localparam int CNT_W = LEN_W + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int ENT_W = DATA_W + 1;
    localparam logic [ADDR_W:0] NUM_CH_W = (ADDR_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1) << LEN_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_LOAD  = 3'd2,
        S_CHECK = 3'd3,
        S_DROP  = 3'd4
    } state_e;

    // Running XOR of header+payload must equal the parity byte and the payload count must equal len.
    function automatic logic pkt_bad(input logic [DATA_W-1:0] xor_v,
                                     input logic [DATA_W-1:0] par_v,
                                     input logic [CNT_W-1:0]  cnt_v,
                                     input logic [LEN_W-1:0]  len_v);
        return (xor_v != par_v) || (cnt_v != {1'b0, len_v});
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   xor_q, xor_d;
    logic [DATA_W-1:0]   par_q, par_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                drop_q, drop_d;

    logic [ADDR_W-1:0]   hdr_addr_s;
    logic [LEN_W-1:0]    hdr_len_s;
    logic                hdr_ok_s;
    logic                hdr_empty_s;
    logic                tgt_empty_s;
    logic                tgt_full_s;
    logic                tgt_flush_s;
    logic [NUM_CH-1:0]   empty_s;
    logic [NUM_CH-1:0]   full_s;
    logic [NUM_CH-1:0]   flush_s;

    logic                busy_s;
    logic                wr_en_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [ENT_W-1:0]    wr_data_s;

    assign hdr_addr_s = din[ADDR_W-1:0];
    assign hdr_len_s  = din[DATA_W-1:ADDR_W];
    assign hdr_ok_s   = ({1'b0, hdr_addr_s} < NUM_CH_W);

    // Status of the channel named by the incoming header and of the latched target channel.
    always_comb begin
        hdr_empty_s = 1'b0;
        tgt_empty_s = 1'b0;
        tgt_full_s  = 1'b0;
        tgt_flush_s = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            hdr_empty_s = hdr_empty_s | (empty_s[k] & (hdr_addr_s == ADDR_W'(k)));
            tgt_empty_s = tgt_empty_s | (empty_s[k] & (addr_q == ADDR_W'(k)));
            tgt_full_s  = tgt_full_s  | (full_s[k]  & (addr_q == ADDR_W'(k)));
            tgt_flush_s = tgt_flush_s | (flush_s[k] & (addr_q == ADDR_W'(k)));
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a flush of the target mid-packet abandons the rest of the packet.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pkt_valid) begin
                    if (!hdr_ok_s) begin
                        state_d = S_DROP;
                    end else if (hdr_empty_s) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (tgt_empty_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_LOAD: begin
                if (tgt_flush_s) begin
                    state_d = (!tgt_full_s && !pkt_valid) ? S_IDLE : S_DROP;
                end else if (!tgt_full_s && !pkt_valid) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_CHECK: state_d = S_IDLE;
            S_DROP: begin
                if (!pkt_valid) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DROP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy towards the source and the FIFO write request.
    always_comb begin
        busy_s    = 1'b0;
        wr_en_s   = 1'b0;
        wr_addr_s = addr_q;
        wr_data_s = {1'b0, din};
        case (state_q)
            S_IDLE: begin
                wr_addr_s = hdr_addr_s;
                if (pkt_valid && hdr_ok_s) begin
                    if (hdr_empty_s) begin
                        wr_en_s   = 1'b1;
                        wr_data_s = {1'b1, din};
                    end else begin
                        busy_s = 1'b1;
                    end
                end else begin
                    busy_s = 1'b0;
                end
            end
            S_WAIT:  busy_s = 1'b1;
            S_LOAD: begin
                busy_s  = tgt_full_s;
                wr_en_s = !tgt_full_s;
            end
            S_CHECK: busy_s = 1'b1;
            S_DROP:  busy_s = 1'b0;
            default: busy_s = 1'b0;
        endcase
    end

    // Packet bookkeeping: target, length, running parity, payload count, error and drop flags.
    always_comb begin
        addr_d = addr_q;
        len_d  = len_q;
        xor_d  = xor_q;
        par_d  = par_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        drop_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pkt_valid) begin
                    addr_d = hdr_addr_s;
                    if (!hdr_ok_s) begin
                        drop_d = 1'b1;
                    end else if (hdr_empty_s) begin
                        len_d = hdr_len_s;
                        err_d = 1'b0;
                        xor_d = din;
                        cnt_d = '0;
                    end else begin
                        len_d = len_q;
                    end
                end else begin
                    addr_d = addr_q;
                end
            end
            S_LOAD: begin
                if (tgt_flush_s) begin
                    err_d  = 1'b1;
                    drop_d = 1'b1;
                end else if (!tgt_full_s) begin
                    if (pkt_valid) begin
                        xor_d = xor_q ^ din;
                        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    end else begin
                        par_d = din;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_CHECK: err_d = pkt_bad(xor_q, par_q, cnt_q, len_q);
            default: err_d = err_q;
        endcase
    end

    // Bookkeeping registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            len_q  <= '0;
            xor_q  <= '0;
            par_q  <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            len_q  <= len_d;
            xor_q  <= xor_d;
            par_q  <= par_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            drop_q <= drop_d;
        end
    end

    assign busy = busy_s;
    assign err  = err_q;
    assign drop = drop_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [ENT_W-1:0]  mem_q [DEPTH];
        logic [PTR_W:0]    wr_ptr_q;
        logic [PTR_W:0]    rd_ptr_q;
        logic [DATA_W-1:0] dout_q;
        logic              sop_q;
        logic              sft_rst_q;
        logic [TMO_W-1:0]  tmo_q;
        logic              rd_s;
        logic              wr_s;

        assign empty_s[k] = (wr_ptr_q == rd_ptr_q);
        assign full_s[k]  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                            (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        assign flush_s[k] = (tmo_q == TMO_W'(TIMEOUT));
        assign rd_s       = rd_en[k] & ~empty_s[k] & ~flush_s[k];
        assign wr_s       = wr_en_s & (wr_addr_s == ADDR_W'(k)) & ~flush_s[k];

        // FIFO pointers; a timeout flush empties the channel.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else if (flush_s[k]) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (wr_s) wr_ptr_q <= wr_ptr_q + (PTR_W + 1)'(1);
                if (rd_s) rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
            end
        end

        // FIFO storage; the extra top bit tags header entries.
        always_ff @(posedge clk) begin
            if (wr_s) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data_s;
        end

        // Registered read port; holds its value when nothing is read.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dout_q <= '0;
                sop_q  <= 1'b0;
            end else if (rd_s) begin
                dout_q <= mem_q[rd_ptr_q[PTR_W-1:0]][DATA_W-1:0];
                sop_q  <= mem_q[rd_ptr_q[PTR_W-1:0]][DATA_W];
            end
        end

        // Unread-cycle counter and flush pulse.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                tmo_q     <= '0;
                sft_rst_q <= 1'b0;
            end else if (flush_s[k]) begin
                tmo_q     <= '0;
                sft_rst_q <= 1'b1;
            end else begin
                sft_rst_q <= 1'b0;
                tmo_q     <= (!empty_s[k] && !rd_en[k]) ? tmo_q + TMO_W'(1) : '0;
            end
        end

        assign dout[k*DATA_W +: DATA_W] = dout_q;
        assign sop[k]                   = sop_q;
        assign vld_out[k]               = ~empty_s[k];
        assign sft_rst[k]               = sft_rst_q;
    end

endmodule
